// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer.
// Contents: default tag width / entry count, the instruction class codes the
// issuer presents on issue_type, and the per-entry life-cycle states.
package reorder_buffer_pkg;

  localparam int DEF_ROB_BITS = 4;
  localparam int DEF_ROB_SIZE = 1 << DEF_ROB_BITS;

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_BRANCH = 2'd1,
    TYPE_STORE  = 2'd2,
    TYPE_JALR   = 2'd3
  } entry_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ISSUED = 2'd1,
    ST_READY  = 2'd2
  } entry_state_e;

  // Sequential fall-through address used when a branch resolves not-taken.
  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_unit.sv
// Combinational decode of the head entry of the reorder buffer.
// Produces the values the top level registers at the next edge:
//   retire        - head leaves the buffer this edge
//   commit_valid  - register write (reg-write or jalr with rd != x0)
//   commit_store  - release the head store to the load/store buffer
//   flush         - mispredicted branch or any jalr
//   flush_pc      - redirect address, 0 when flush is low
module reorder_buffer_commit_unit
  import reorder_buffer_pkg::*;
(
  input  entry_state_e head_state,
  input  entry_type_e  head_type,
  input  logic [4:0]   head_rd,
  input  logic [31:0]  head_pc,
  input  logic         head_pred_taken,
  input  logic         head_taken,
  input  logic [31:0]  head_target,
  input  logic         flush_pending,
  output logic         retire,
  output logic         commit_valid,
  output logic         commit_store,
  output logic         flush,
  output logic [31:0]  flush_pc
);

  always_comb begin
    retire       = 1'b0;
    commit_valid = 1'b0;
    commit_store = 1'b0;
    flush        = 1'b0;
    flush_pc     = 32'd0;
    // The buffer is being emptied during a flush cycle; nothing retires.
    if (head_state == ST_READY && !flush_pending) begin
      retire = 1'b1;
      unique case (head_type)
        TYPE_REG: begin
          commit_valid = (head_rd != 5'd0);
        end
        TYPE_STORE: begin
          commit_store = 1'b1;
        end
        TYPE_BRANCH: begin
          if (head_taken != head_pred_taken) begin
            flush    = 1'b1;
            flush_pc = head_taken ? head_target : fallthrough_pc(head_pc);
          end
        end
        TYPE_JALR: begin
          // Indirect jumps are never predicted, so they always redirect.
          commit_valid = (head_rd != 5'd0);
          flush        = 1'b1;
          flush_pc     = head_target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, collects ALU (wb1) and
// LSB (wb2) results, rebroadcasts them on two CDB buses, answers operand
// queries and retires one instruction per cycle in program order.
//
// Handshakes: issue_valid, wb1_valid and wb2_valid are single-cycle strobes
// with no ready return; the only backpressure is rob_full, which the issuer
// must observe before raising issue_valid. All outputs with a valid strobe
// (bc*, commit_*, flush) are registered one-cycle pulses, and read 0
// whenever rdy_in is low.
//
// Ports: clk_in/rst_in/rdy_in; issue_* -> allocate at rob_tail; wb1_*/wb2_*
// results; bc1_*/bc2_* broadcasts; query_id_N -> query_busy_N/query_value_N;
// commit_* register retire; commit_store; flush/flush_pc.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_BITS = DEF_ROB_BITS,
  parameter int SIZE     = DEF_ROB_SIZE   // must equal 1 << ROB_BITS
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                issue_valid,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_rd,
  input  logic [31:0]         issue_pc,
  input  logic                issue_pred_taken,
  output logic [ROB_BITS-1:0] rob_tail,
  output logic                rob_full,
  input  logic                wb1_valid,
  input  logic [ROB_BITS-1:0] wb1_id,
  input  logic [31:0]         wb1_value,
  input  logic                wb1_taken,
  input  logic [31:0]         wb1_target,
  input  logic                wb2_valid,
  input  logic [ROB_BITS-1:0] wb2_id,
  input  logic [31:0]         wb2_value,
  output logic                bc1_valid,
  output logic [ROB_BITS-1:0] bc1_id,
  output logic [31:0]         bc1_value,
  output logic                bc2_valid,
  output logic [ROB_BITS-1:0] bc2_id,
  output logic [31:0]         bc2_value,
  input  logic [ROB_BITS-1:0] query_id_1,
  output logic                query_busy_1,
  output logic [31:0]         query_value_1,
  input  logic [ROB_BITS-1:0] query_id_2,
  output logic                query_busy_2,
  output logic [31:0]         query_value_2,
  output logic                commit_valid,
  output logic [4:0]          commit_rd,
  output logic [ROB_BITS-1:0] commit_id,
  output logic [31:0]         commit_value,
  output logic                commit_store,
  output logic                flush,
  output logic [31:0]         flush_pc
);

  // One extra bit so that full (SIZE) and empty (0) are distinct.
  localparam int CW = ROB_BITS + 1;

  entry_state_e  state_q  [SIZE];
  entry_type_e   type_q   [SIZE];
  logic [4:0]    rd_q     [SIZE];
  logic [31:0]   pc_q     [SIZE];
  logic          pred_q   [SIZE];
  logic [31:0]   value_q  [SIZE];
  logic          taken_q  [SIZE];
  logic [31:0]   target_q [SIZE];

  logic [ROB_BITS-1:0] head_q, tail_q;
  logic [CW-1:0]       count_q;
  logic                flush_pending_q;

  logic                bc1_valid_q, bc2_valid_q;
  logic [ROB_BITS-1:0] bc1_id_q, bc2_id_q;
  logic [31:0]         bc1_value_q, bc2_value_q;
  logic                commit_valid_q, commit_store_q, flush_q;
  logic [4:0]          commit_rd_q;
  logic [ROB_BITS-1:0] commit_id_q;
  logic [31:0]         commit_value_q, flush_pc_q;

  logic        cu_retire, cu_commit_valid, cu_commit_store, cu_flush;
  logic [31:0] cu_flush_pc;
  logic        issue_accept, wb1_accept, wb2_accept;

  reorder_buffer_commit_unit u_commit (
    .head_state      (state_q[head_q]),
    .head_type       (type_q[head_q]),
    .head_rd         (rd_q[head_q]),
    .head_pc         (pc_q[head_q]),
    .head_pred_taken (pred_q[head_q]),
    .head_taken      (taken_q[head_q]),
    .head_target     (target_q[head_q]),
    .flush_pending   (flush_pending_q),
    .retire          (cu_retire),
    .commit_valid    (cu_commit_valid),
    .commit_store    (cu_commit_store),
    .flush           (cu_flush),
    .flush_pc        (cu_flush_pc)
  );

  assign rob_full = (count_q == CW'(SIZE));
  assign rob_tail = tail_q;

  // Full is judged on the registered count, so a full buffer refuses issue
  // even in the cycle its head retires.
  assign issue_accept = issue_valid && !rob_full && !flush_pending_q;
  // Results are dropped during a flush cycle and on the edge that starts one,
  // since every entry is being discarded anyway.
  assign wb1_accept = wb1_valid && (state_q[wb1_id] == ST_ISSUED) && !flush_pending_q && !cu_flush;
  assign wb2_accept = wb2_valid && (state_q[wb2_id] == ST_ISSUED) && !flush_pending_q && !cu_flush;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        state_q[i]  <= ST_EMPTY;
        type_q[i]   <= TYPE_REG;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        pred_q[i]   <= 1'b0;
        value_q[i]  <= '0;
        taken_q[i]  <= 1'b0;
        target_q[i] <= '0;
      end
      bc1_valid_q    <= 1'b0;
      bc1_id_q       <= '0;
      bc1_value_q    <= '0;
      bc2_valid_q    <= 1'b0;
      bc2_id_q       <= '0;
      bc2_value_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_id_q    <= '0;
      commit_value_q <= '0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy_in) begin
      bc1_valid_q    <= wb1_accept;
      bc1_id_q       <= wb1_accept ? wb1_id : '0;
      bc1_value_q    <= wb1_accept ? wb1_value : '0;
      bc2_valid_q    <= wb2_accept;
      bc2_id_q       <= wb2_accept ? wb2_id : '0;
      bc2_value_q    <= wb2_accept ? wb2_value : '0;
      commit_valid_q <= cu_commit_valid;
      commit_rd_q    <= cu_commit_valid ? rd_q[head_q] : '0;
      commit_id_q    <= cu_commit_valid ? head_q : '0;
      commit_value_q <= cu_commit_valid ? value_q[head_q] : '0;
      commit_store_q <= cu_commit_store;
      flush_q        <= cu_flush;
      flush_pc_q     <= cu_flush_pc;

      if (cu_flush) begin
        // Everything younger than the redirecting instruction is wrong-path.
        for (int i = 0; i < SIZE; i++) state_q[i] <= ST_EMPTY;
        head_q          <= '0;
        tail_q          <= '0;
        count_q         <= '0;
        flush_pending_q <= 1'b1;
      end else begin
        flush_pending_q <= 1'b0;
        if (wb1_accept) begin
          state_q[wb1_id]  <= ST_READY;
          value_q[wb1_id]  <= wb1_value;
          taken_q[wb1_id]  <= wb1_taken;
          target_q[wb1_id] <= wb1_target;
        end
        if (wb2_accept) begin
          state_q[wb2_id] <= ST_READY;
          value_q[wb2_id] <= wb2_value;
        end
        if (cu_retire) begin
          state_q[head_q] <= ST_EMPTY;
          head_q          <= head_q + 1'b1;
        end
        // Tail slot is EMPTY whenever issue is accepted, so it never
        // collides with the writeback or retire updates above.
        if (issue_accept) begin
          state_q[tail_q]  <= ST_ISSUED;
          type_q[tail_q]   <= entry_type_e'(issue_type);
          rd_q[tail_q]     <= issue_rd;
          pc_q[tail_q]     <= issue_pc;
          pred_q[tail_q]   <= issue_pred_taken;
          value_q[tail_q]  <= '0;
          taken_q[tail_q]  <= 1'b0;
          target_q[tail_q] <= '0;
          tail_q           <= tail_q + 1'b1;
        end
        count_q <= count_q + CW'(issue_accept) - CW'(cu_retire);
      end
    end
  end

  assign query_busy_1  = (state_q[query_id_1] != ST_READY);
  assign query_value_1 = value_q[query_id_1];
  assign query_busy_2  = (state_q[query_id_2] != ST_READY);
  assign query_value_2 = value_q[query_id_2];

  // Pulse outputs are held in their registers while stalled but read as 0.
  assign bc1_valid    = rdy_in & bc1_valid_q;
  assign bc1_id       = rdy_in ? bc1_id_q : '0;
  assign bc1_value    = rdy_in ? bc1_value_q : '0;
  assign bc2_valid    = rdy_in & bc2_valid_q;
  assign bc2_id       = rdy_in ? bc2_id_q : '0;
  assign bc2_value    = rdy_in ? bc2_value_q : '0;
  assign commit_valid = rdy_in & commit_valid_q;
  assign commit_rd    = rdy_in ? commit_rd_q : '0;
  assign commit_id    = rdy_in ? commit_id_q : '0;
  assign commit_value = rdy_in ? commit_value_q : '0;
  assign commit_store = rdy_in & commit_store_q;
  assign flush        = rdy_in & flush_q;
  assign flush_pc     = rdy_in ? flush_pc_q : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by a
// long randomized run compared against a program-order queue model.
module tb_reorder_buffer;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_type = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_pc = '0;
  logic        issue_pred_taken = 1'b0;
  logic [3:0]  rob_tail;
  logic        rob_full;
  logic        wb1_valid = 1'b0, wb2_valid = 1'b0;
  logic [3:0]  wb1_id = '0, wb2_id = '0;
  logic [31:0] wb1_value = '0, wb2_value = '0, wb1_target = '0;
  logic        wb1_taken = 1'b0;
  logic        bc1_valid, bc2_valid;
  logic [3:0]  bc1_id, bc2_id;
  logic [31:0] bc1_value, bc2_value;
  logic [3:0]  query_id_1 = '0, query_id_2 = '0;
  logic        query_busy_1, query_busy_2;
  logic [31:0] query_value_1, query_value_2;
  logic        commit_valid, commit_store, flush;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_id;
  logic [31:0] commit_value, flush_pc;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .rob_tail(rob_tail), .rob_full(rob_full),
    .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_value(wb1_value),
    .wb1_taken(wb1_taken), .wb1_target(wb1_target),
    .wb2_valid(wb2_valid), .wb2_id(wb2_id), .wb2_value(wb2_value),
    .bc1_valid(bc1_valid), .bc1_id(bc1_id), .bc1_value(bc1_value),
    .bc2_valid(bc2_valid), .bc2_id(bc2_id), .bc2_value(bc2_value),
    .query_id_1(query_id_1), .query_busy_1(query_busy_1), .query_value_1(query_value_1),
    .query_id_2(query_id_2), .query_busy_2(query_busy_2), .query_value_2(query_value_2),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_id(commit_id),
    .commit_value(commit_value), .commit_store(commit_store),
    .flush(flush), .flush_pc(flush_pc)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Program-order list of live instructions; front is the oldest.
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        ready;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        rob_m[$];
  logic [3:0]  tail_m;
  bit          pend_m;
  logic [40:0] exp_q[$];   // {rd, tag, value} of expected register commits

  logic        e_bc1_v, e_bc2_v, e_cv, e_cs, e_fl;
  logic [3:0]  e_bc1_id, e_bc2_id, e_cid;
  logic [31:0] e_bc1_val, e_bc2_val, e_cval, e_flpc;
  logic [4:0]  e_crd;

  task automatic model_reset();
    rob_m.delete();
    exp_q.delete();
    tail_m = '0;
    pend_m = 0;
  endtask

  // Computes what the next clock edge should produce from the inputs
  // currently driven, and advances the model to the post-edge state.
  task automatic model_step();
    int   n0, i1, i2;
    ent_t h, e;
    bit   writes;
    e_bc1_v = 0; e_bc2_v = 0; e_cv = 0; e_cs = 0; e_fl = 0;
    e_bc1_id = '0; e_bc2_id = '0; e_cid = '0; e_crd = '0;
    e_bc1_val = '0; e_bc2_val = '0; e_cval = '0; e_flpc = '0;
    if (!rdy_in) return;
    if (pend_m) begin
      pend_m = 0;
      return;
    end
    n0 = rob_m.size();
    i1 = -1;
    i2 = -1;
    for (int k = 0; k < n0; k++) begin
      if (wb1_valid && rob_m[k].tag == wb1_id && !rob_m[k].ready) i1 = k;
      if (wb2_valid && rob_m[k].tag == wb2_id && !rob_m[k].ready) i2 = k;
    end
    if (n0 > 0 && rob_m[0].ready) begin
      h = rob_m[0];
      writes = (h.typ == 2'd0 || h.typ == 2'd3) && h.rd != 5'd0;
      if (writes) begin
        e_cv = 1; e_crd = h.rd; e_cid = h.tag; e_cval = h.value;
        exp_q.push_back({h.rd, h.tag, h.value});
      end
      if (h.typ == 2'd2) e_cs = 1;
      if (h.typ == 2'd3 || (h.typ == 2'd1 && h.taken != h.pred)) begin
        e_fl = 1;
        e_flpc = (h.typ == 2'd3 || h.taken) ? h.target : h.pc + 32'd4;
        rob_m.delete();
        tail_m = '0;
        pend_m = 1;
        return;
      end
      void'(rob_m.pop_front());
      i1--;
      i2--;
    end
    if (i1 >= 0) begin
      rob_m[i1].ready = 1; rob_m[i1].value = wb1_value;
      rob_m[i1].taken = wb1_taken; rob_m[i1].target = wb1_target;
      e_bc1_v = 1; e_bc1_id = wb1_id; e_bc1_val = wb1_value;
    end
    if (i2 >= 0) begin
      rob_m[i2].ready = 1; rob_m[i2].value = wb2_value;
      e_bc2_v = 1; e_bc2_id = wb2_id; e_bc2_val = wb2_value;
    end
    if (issue_valid && n0 < 16) begin
      e.tag = tail_m; e.typ = issue_type; e.rd = issue_rd; e.pc = issue_pc;
      e.pred = issue_pred_taken; e.ready = 0; e.value = '0; e.taken = 0; e.target = '0;
      rob_m.push_back(e);
      tail_m = tail_m + 4'd1;
    end
  endtask

  task automatic model_query(input logic [3:0] t, output logic busy, output logic [31:0] v);
    busy = 1;
    v = '0;
    foreach (rob_m[k]) if (rob_m[k].tag == t && rob_m[k].ready) begin
      busy = 0;
      v = rob_m[k].value;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; wb1_valid = 0; wb2_valid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rdy_in = 1;
    rst_in = 1;
    @(posedge clk_in);
    #1;
    rst_in = 0;
    model_reset();
  endtask

  task automatic issue_one(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_pc = pc; issue_pred_taken = pred;
    tick();
    issue_valid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      query_id_1 = 4'(i);
      query_id_2 = 4'(15 - i);
      #1;
      if (query_busy_1 !== 1'b1 || query_busy_2 !== 1'b1 || query_value_1 !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_query_busy: %0d tags not busy/zero, want 0", bad); end
    checks++;
    if ({rob_tail, rob_full, bc1_valid, bc2_valid, commit_valid, commit_store, flush, flush_pc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: tail=%0d full=%0b bc=%b%b cv=%b cs=%b fl=%b flpc=%h, want all 0",
               rob_tail, rob_full, bc1_valid, bc2_valid, commit_valid, commit_store, flush, flush_pc);
    end
    do_reset();
  endtask

  task automatic test_reset_midrun();
    int bad;
    do_reset();
    for (int i = 0; i < 5; i++) issue_one(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
    wb1_valid = 1; wb1_id = 4'd0; wb1_value = 32'h77;
    #2 rst_in = 1;
    #1;
    wb1_valid = 0;
    checks++;
    if (rob_tail !== 4'd0 || rob_full !== 1'b0 || commit_valid !== 1'b0 || bc1_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: tail=%0d full=%0b cv=%b bc1=%b, want 0 0 0 0", rob_tail, rob_full, commit_valid, bc1_valid);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      query_id_1 = 4'(i);
      #1;
      if (query_busy_1 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midrun_query_busy: %0d tags not busy, want 0", bad); end
    @(posedge clk_in);
    #1;
    rst_in = 0;
    model_reset();
    tick();
    checks++;
    if (rob_tail !== 4'd0 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrun_after: tail=%0d cv=%b, want 0 0", rob_tail, commit_valid);
    end
  endtask

  task automatic test_basic_commit();
    do_reset();
    issue_one(2'd0, 5'd5, 32'h0, 1'b0);
    checks++;
    if (rob_tail !== 4'd1) begin failures++; $display("FAIL basic_tail: got %0d want 1", rob_tail); end
    wb1_valid = 1; wb1_id = 4'd0; wb1_value = 32'h1234; wb1_taken = 0; wb1_target = 0;
    tick();
    wb1_valid = 0;
    checks++;
    if (bc1_valid !== 1'b1 || bc1_id !== 4'd0 || bc1_value !== 32'h1234 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_bc1: v=%b id=%0d val=%h cv=%b, want 1 0 1234 0", bc1_valid, bc1_id, bc1_value, commit_valid);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_id !== 4'd0 || commit_value !== 32'h1234 || bc1_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_commit: cv=%b rd=%0d id=%0d val=%h bc1=%b, want 1 5 0 1234 0",
               commit_valid, commit_rd, commit_id, commit_value, bc1_valid);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse: cv=%b want 0", commit_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rob_full !== 1'b0) begin failures++; $display("FAIL fill_early_full: at %0d full=1 want 0", i); end
      issue_one(2'd0, 5'd1, 32'(i * 4), 1'b0);
    end
    checks++;
    if (rob_full !== 1'b1 || rob_tail !== 4'd0) begin
      failures++; $display("FAIL full_set: full=%b tail=%0d, want 1 0", rob_full, rob_tail);
    end
    issue_one(2'd0, 5'd2, 32'h40, 1'b0);
    checks++;
    if (rob_full !== 1'b1 || rob_tail !== 4'd0) begin
      failures++; $display("FAIL full_drop: full=%b tail=%0d, want 1 0", rob_full, rob_tail);
    end
    wb1_valid = 1; wb1_id = 4'd0; wb1_value = 32'h7;
    tick();
    wb1_valid = 0;
    issue_valid = 1; issue_type = 2'd0; issue_rd = 5'd3; issue_pc = 32'h80;
    tick();
    issue_valid = 0;
    checks++;
    if (commit_valid !== 1'b1 || commit_id !== 4'd0 || rob_tail !== 4'd0 || rob_full !== 1'b0) begin
      failures++;
      $display("FAIL full_commit_refuse: cv=%b id=%0d tail=%0d full=%b, want 1 0 0 0", commit_valid, commit_id, rob_tail, rob_full);
    end
    issue_one(2'd0, 5'd3, 32'h80, 1'b0);
    checks++;
    if (rob_tail !== 4'd1 || rob_full !== 1'b1) begin
      failures++; $display("FAIL wrap_issue: tail=%0d full=%b, want 1 1", rob_tail, rob_full);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    issue_one(2'd0, 5'd3, 32'h0, 1'b0);
    issue_one(2'd0, 5'd4, 32'h4, 1'b0);
    wb1_valid = 1; wb1_id = 4'd1; wb1_value = 32'hA1;
    tick();
    wb1_valid = 0;
    query_id_1 = 4'd1; query_id_2 = 4'd0;
    #1;
    checks++;
    if (query_busy_1 !== 1'b0 || query_value_1 !== 32'hA1 || query_busy_2 !== 1'b1) begin
      failures++;
      $display("FAIL ooo_query: busy1=%b val1=%h busy2=%b, want 0 a1 1", query_busy_1, query_value_1, query_busy_2);
    end
    wb1_valid = 1; wb1_id = 4'd0; wb1_value = 32'hB0;
    tick();
    wb1_valid = 0;
    checks++;
    if (commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_no_early: cv=%b want 0", commit_valid); end
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_id !== 4'd0 || commit_rd !== 5'd3 || commit_value !== 32'hB0) begin
      failures++; $display("FAIL ooo_first: cv=%b id=%0d rd=%0d val=%h, want 1 0 3 b0", commit_valid, commit_id, commit_rd, commit_value);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_id !== 4'd1 || commit_rd !== 5'd4 || commit_value !== 32'hA1) begin
      failures++; $display("FAIL ooo_second: cv=%b id=%0d rd=%0d val=%h, want 1 1 4 a1", commit_valid, commit_id, commit_rd, commit_value);
    end
  endtask

  task automatic test_branch_flush();
    int stray;
    do_reset();
    issue_one(2'd1, 5'd0, 32'h100, 1'b0);
    for (int i = 1; i <= 3; i++) issue_one(2'd0, 5'(i + 5), 32'h100 + 32'(4 * i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      wb2_valid = 1; wb2_id = 4'(i); wb2_value = 32'(i);
      tick();
    end
    wb2_valid = 0;
    wb1_valid = 1; wb1_id = 4'd0; wb1_value = 32'h0; wb1_taken = 1; wb1_target = 32'h200;
    tick();
    wb1_valid = 0;
    tick();
    checks++;
    if (flush !== 1'b1 || flush_pc !== 32'h200 || rob_tail !== 4'd0 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_flush: fl=%b pc=%h tail=%0d cv=%b, want 1 200 0 0", flush, flush_pc, rob_tail, commit_valid);
    end
    issue_valid = 1; issue_type = 2'd0; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    checks++;
    if (rob_tail !== 4'd0 || flush !== 1'b0) begin
      failures++; $display("FAIL flush_drop_issue: tail=%0d fl=%b, want 0 0", rob_tail, flush);
    end
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (commit_valid !== 1'b0) stray++;
    end
    query_id_1 = 4'd1;
    #1;
    checks++;
    if (stray != 0 || query_busy_1 !== 1'b1) begin
      failures++; $display("FAIL flush_younger: stray commits=%0d busy=%b, want 0 1", stray, query_busy_1);
    end
  endtask

  task automatic test_jalr();
    do_reset();
    issue_one(2'd3, 5'd1, 32'h40, 1'b0);
    wb1_valid = 1; wb1_id = 4'd0; wb1_value = 32'h44; wb1_taken = 0; wb1_target = 32'h80;
    tick();
    wb1_valid = 0;
    tick();
    checks++;
    if (flush !== 1'b1 || flush_pc !== 32'h80 || commit_valid !== 1'b1 || commit_rd !== 5'd1 || commit_value !== 32'h44) begin
      failures++;
      $display("FAIL jalr: fl=%b pc=%h cv=%b rd=%0d val=%h, want 1 80 1 1 44", flush, flush_pc, commit_valid, commit_rd, commit_value);
    end
  endtask

  task automatic test_dual_wb_store();
    int stores;
    do_reset();
    issue_one(2'd2, 5'd0, 32'h0, 1'b0);
    issue_one(2'd0, 5'd7, 32'h4, 1'b0);
    issue_one(2'd0, 5'd8, 32'h8, 1'b0);
    issue_one(2'd0, 5'd9, 32'hC, 1'b0);
    wb1_valid = 1; wb1_id = 4'd2; wb1_value = 32'hAAAA; wb1_taken = 0;
    wb2_valid = 1; wb2_id = 4'd3; wb2_value = 32'hBBBB;
    tick();
    clear_inputs();
    checks++;
    if ({bc1_valid, bc1_id, bc1_value, bc2_valid, bc2_id, bc2_value} !== {1'b1, 4'd2, 32'hAAAA, 1'b1, 4'd3, 32'hBBBB}) begin
      failures++;
      $display("FAIL dual_bc: bc1=%b/%0d/%h bc2=%b/%0d/%h, want 1/2/aaaa 1/3/bbbb", bc1_valid, bc1_id, bc1_value, bc2_valid, bc2_id, bc2_value);
    end
    wb2_valid = 1; wb2_id = 4'd0; wb2_value = 32'h500;
    tick();
    wb2_valid = 0;
    checks++;
    if (bc1_valid !== 1'b0) begin failures++; $display("FAIL dual_bc_pulse: bc1=%b want 0", bc1_valid); end
    stores = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (commit_store === 1'b1) stores++;
    end
    checks++;
    if (stores != 1) begin failures++; $display("FAIL store_release: pulses=%0d want 1", stores); end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    issue_one(2'd0, 5'd2, 32'h0, 1'b0);
    wb1_valid = 1; wb1_id = 4'd0; wb1_value = 32'h55;
    tick();
    wb1_valid = 0;
    rdy_in = 0;
    issue_valid = 1; issue_type = 2'd0; issue_rd = 5'd3;
    #1;
    checks++;
    if (bc1_valid !== 1'b0 || bc1_value !== 32'd0) begin
      failures++; $display("FAIL rdy_mask: bc1=%b val=%h, want 0 0", bc1_valid, bc1_value);
    end
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    checks++;
    if (rob_tail !== 4'd1 || commit_valid !== 1'b0) begin
      failures++; $display("FAIL rdy_hold: tail=%0d cv=%b, want 1 0", rob_tail, commit_valid);
    end
    issue_valid = 0;
    rdy_in = 1;
    @(posedge clk_in); #1;
    checks++;
    if (commit_valid !== 1'b1 || commit_value !== 32'h55 || commit_rd !== 5'd2) begin
      failures++; $display("FAIL rdy_resume: cv=%b val=%h rd=%0d, want 1 55 2", commit_valid, commit_value, commit_rd);
    end
    do_reset();
  endtask

  task automatic test_random(input int cycles);
    int          cand[$];
    int          k, r;
    logic        qb;
    logic [31:0] qv;
    logic [40:0] got;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      issue_type = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue_pc = 32'($urandom_range(0, 16383)) << 2;
      issue_pred_taken = 1'($urandom_range(0, 1));
      cand.delete();
      foreach (rob_m[i]) if (!rob_m[i].ready) cand.push_back(int'(rob_m[i].tag));
      wb1_valid = 0;
      wb2_valid = 0;
      wb1_value = $urandom; wb2_value = $urandom;
      wb1_taken = 1'($urandom_range(0, 1));
      wb1_target = 32'($urandom_range(0, 16383)) << 2;
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, cand.size() - 1);
        wb1_valid = 1; wb1_id = 4'(cand[k]);
        cand.delete(k);
      end else if ($urandom_range(0, 3) == 0) begin
        wb1_valid = 1; wb1_id = 4'($urandom_range(0, 15));
      end
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, cand.size() - 1);
        if (!(wb1_valid && 4'(cand[k]) == wb1_id)) begin
          wb2_valid = 1; wb2_id = 4'(cand[k]);
        end
      end
      query_id_1 = 4'($urandom_range(0, 15));
      query_id_2 = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if ({bc1_valid, bc2_valid, commit_valid, commit_store, flush} !== {e_bc1_v, e_bc2_v, e_cv, e_cs, e_fl}) begin
        failures++;
        $display("FAIL rnd_strobes c=%0d: bc1 bc2 cv cs fl=%b%b%b%b%b want %b%b%b%b%b", c,
                 bc1_valid, bc2_valid, commit_valid, commit_store, flush, e_bc1_v, e_bc2_v, e_cv, e_cs, e_fl);
      end
      if (e_bc1_v) begin
        checks++;
        if (bc1_id !== e_bc1_id || bc1_value !== e_bc1_val) begin
          failures++; $display("FAIL rnd_bc1 c=%0d: %0d/%h want %0d/%h", c, bc1_id, bc1_value, e_bc1_id, e_bc1_val);
        end
      end
      if (e_bc2_v) begin
        checks++;
        if (bc2_id !== e_bc2_id || bc2_value !== e_bc2_val) begin
          failures++; $display("FAIL rnd_bc2 c=%0d: %0d/%h want %0d/%h", c, bc2_id, bc2_value, e_bc2_id, e_bc2_val);
        end
      end
      if (commit_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_commit_extra c=%0d: rd=%0d id=%0d, want none", c, commit_rd, commit_id);
        end else begin
          got = exp_q.pop_front();
          if ({commit_rd, commit_id, commit_value} !== got) begin
            failures++; $display("FAIL rnd_commit c=%0d: %h want %h", c, {commit_rd, commit_id, commit_value}, got);
          end
        end
      end
      if (e_fl) begin
        checks++;
        if (flush_pc !== e_flpc) begin failures++; $display("FAIL rnd_flush_pc c=%0d: %h want %h", c, flush_pc, e_flpc); end
      end
      checks++;
      if (rob_tail !== tail_m || rob_full !== (rob_m.size() == 16)) begin
        failures++;
        $display("FAIL rnd_tail c=%0d: tail=%0d full=%b want %0d %b", c, rob_tail, rob_full, tail_m, rob_m.size() == 16);
      end
      model_query(query_id_1, qb, qv);
      checks++;
      if (query_busy_1 !== qb || (!qb && query_value_1 !== qv)) begin
        failures++; $display("FAIL rnd_query1 c=%0d: busy=%b val=%h want %b %h", c, query_busy_1, query_value_1, qb, qv);
      end
      model_query(query_id_2, qb, qv);
      checks++;
      if (query_busy_2 !== qb || (!qb && query_value_2 !== qv)) begin
        failures++; $display("FAIL rnd_query2 c=%0d: busy=%b val=%h want %b %h", c, query_busy_2, query_value_2, qb, qv);
      end
    end
    clear_inputs();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_missed_commits: %0d left want 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_reset();
    #2;
    test_reset();
    test_basic_commit();
    test_full_wrap();
    test_out_of_order();
    test_branch_flush();
    test_jalr();
    test_dual_wb_store();
    test_rdy_hold();
    test_reset_midrun();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer for the Tomasulo RISC-V core. It allocates tags for issued instructions and hands the tail tag to the reservation station and the LSB. It accepts results from the ALU and LSB, rebroadcasts them as the two CDB result buses the reservation stations snoop, and answers operand-lookup queries. It retires one instruction per cycle in program order: register writes, store release, and branch-mispredict flush.

Parameters:
ROB_BITS, 4, tag width; entry count is 2^ROB_BITS.
SIZE, 16, entry count; must equal 1<<ROB_BITS.

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-high
rdy_in  in  1  when low, hold all state and force pulse outputs to 0
issue_valid  in  1  allocate an entry this cycle
issue_type  in  2  0=reg write, 1=branch, 2=store, 3=jalr
issue_rd  in  5  destination register; x0 means no write
issue_pc  in  32  instruction PC
issue_pred_taken  in  1  predictor decision, branch only
rob_tail  out  ROB_BITS  tag the next issue receives
rob_full  out  1  count==SIZE
wb1_valid / wb2_valid  in  1  ALU / LSB result strobe
wb1_id / wb2_id  in  ROB_BITS  result tag
wb1_value / wb2_value  in  32  result value
wb1_taken  in  1  resolved branch direction (ALU port only)
wb1_target  in  32  resolved jump target (ALU port only)
bc1_valid / bc2_valid  out  1  CDB broadcast strobe
bc1_id / bc2_id  out  ROB_BITS  broadcast tag
bc1_value / bc2_value  out  32  broadcast value
query_id_1 / query_id_2  in  ROB_BITS  operand lookup tag
query_busy_1 / query_busy_2  out  1  1 = result not yet present
query_value_1 / query_value_2  out  32  stored value when not busy
commit_valid  out  1  register write retire pulse
commit_rd  out  5  destination register
commit_id  out  ROB_BITS  retired tag; register file clears its tag if it matches
commit_value  out  32  value written
commit_store  out  1  pulse releasing the head store to the LSB
flush  out  1  mispredict pulse
flush_pc  out  32  redirect PC

Behaviour:
- Entry state per slot: EMPTY -> ISSUED (on issue) -> READY (on writeback) -> EMPTY (on commit or flush). Stored per entry: type, rd, pc, pred_taken, value, taken, target.
- Reset (asynchronous): head=0, tail=0, count=0, all entries EMPTY. All outputs 0, except rob_tail=0 and query_busy_*=1.
- Issue:
  - Accepted iff issue_valid && !rob_full && !flush_pending.
  - Writes the entry at tail; tail <= tail+1 mod SIZE; count+1.
  - Issue while full is dropped silently; the issuer must gate on rob_full.
- Writeback:
  - wbN_valid sets entry wbN_id to READY and latches value; port 1 also latches taken and target.
  - Writeback to a non-ISSUED entry is ignored.
  - Both ports may write in the same cycle to distinct tags.
- Broadcast: bcN_* = wbN_* registered. The bus is valid exactly one cycle after an accepted writeback and is a one-cycle pulse.
- Query: combinational. query_busy_N = (entry state != READY); query_value_N = entry value.
- Commit, at most one per cycle, when the head entry is READY:
  - Type 0 with rd!=0: commit_valid=1, commit_rd, commit_id, commit_value.
  - Type 0 with rd=0: retire silently.
  - Type 2: commit_store=1.
  - Type 1: if taken!=pred_taken, assert flush. flush_pc = taken ? target : pc+4.
  - Type 3: always assert flush with flush_pc=target. commit_valid for rd is still asserted.
  - Head advances mod SIZE; count-1. All commit outputs are registered one-cycle pulses.
  - Latency: wb at cycle N -> READY at N+1 -> commit pulse visible at N+2.
- Flush:
  - In the cycle flush is asserted, every entry becomes EMPTY and head=tail=count=0.
  - Issue and writebacks arriving in that cycle are discarded.
  - flush_pending is the internal flag set on the committing edge and cleared the next edge.
- Simultaneous issue and commit: count is unchanged. rob_full is evaluated from the registered count, so a full buffer refuses issue in the cycle it commits.
- Wrap-around: tail=SIZE-1 issues to slot SIZE-1, then tail=0. Full and empty are distinguished by count, never by pointer equality.
- rdy_in low: no state change; bc*, commit_*, flush read 0.

Decomposition:
- Shared const.v: ROB_BITS, ROB_SIZE, entry-type encodings, state encodings (EMPTY/ISSUED/READY).
- One sub-module is natural: rob_commit_unit. It is combinational head decode producing the next-cycle commit, flush and flush_pc values; the top level registers them.

Test Plan:
- Reset mid-run with 5 entries live -> next cycle count=0, rob_tail=0, all query_busy=1, no commit pulse.
- Issue rd=5 (tag 0); wb1 id=0 value=0x1234 -> bc1 (id 0, 0x1234) next cycle; commit_valid with rd=5, value=0x1234 two cycles after wb.
- Fill 16 entries -> rob_full=1 and a 17th issue is dropped. Commit head and issue in the same cycle -> issue refused. Next cycle issue accepted with tag 0 (wrap).
- Out-of-order wb: tags 1 then 0 complete -> commits occur in order 0,1; query_id_1=1 reads busy=0 and the value before tag 1 retires.
- Branch pc=0x100, pred=0, wb taken=1 target=0x200, with 3 younger entries -> flush=1, flush_pc=0x200, all younger entries never commit, rob_tail=0.
- Simultaneous wb1 id=2 and wb2 id=3 -> both bc buses pulse the next cycle; store at head releases commit_store once.
